traffic_inject_ctrl: RTL

- Injection controller for one router local port in the NoC traffic bench.
- Sequences an external 8-bit XNOR LFSR traffic generator: drives its enable and consumes its 8-bit output.
- Uses the LFSR value both to decide, by rate threshold, when a packet starts and as flit payload.
- Forms head/body/tail flits and issues them under credit-based flow control to the router input buffer.

---
 rtl/traffic_inject_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/traffic_inject_ctrl.sv
// traffic_inject_ctrl: injection controller for one NoC router local port.
// Gates packet starts with an external 8-bit LFSR against a rate threshold,
// uses the LFSR value as flit payload and issues head/body/tail flits under
// credit-based flow control.
// Ports: clk, reset (async, active-high); start/stop run control;
//   cfg_rate/cfg_dest/cfg_num_pkts run configuration (latched on start);
//   lfsr_in/lfsr_en traffic generator link; credit_in downstream credits;
//   flit_valid/flit_type/flit_data flit output; busy/done/pkt_cnt status;
//   credit_err sticky overflow flag; stall_cnt stall-cycle statistic.
// Build option: define TRAFFIC_STATS_EN to build the saturating stall
//   counter; otherwise stall_cnt is tied to zero.
module traffic_inject_ctrl #(
  parameter int PKT_LEN = 4,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       cfg_rate,
  input  logic [3:0]       cfg_dest,
  input  logic [CNT_W-1:0] cfg_num_pkts,
  input  logic [7:0]       lfsr_in,
  output logic             lfsr_en,
  input  logic             credit_in,
  output logic             flit_valid,
  output logic [1:0]       flit_type,
  output logic [7:0]       flit_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             credit_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    FLIT,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       rate_q;
  logic [3:0]       dest_q;
  logic [CNT_W-1:0] num_q;
  logic [4:0]       idx;
  logic [3:0]       credit_cnt;

  logic             issue;
  logic             is_head;
  logic             is_tail;
  logic             last_pkt;
  logic             can_start;
  logic [CNT_W-1:0] pkt_nxt;

  assign issue     = (state == FLIT) && (credit_cnt != 4'd0);
  assign is_head   = (idx == 5'd0);
  assign is_tail   = (idx == 5'(PKT_LEN - 1));
  assign pkt_nxt   = pkt_cnt + CNT_W'(1);
  assign last_pkt  = (num_q != '0) && (pkt_nxt == num_q);
  assign can_start = start && ((state == IDLE) || (state == DONE));

  // Generator advances only when its value is consumed.
  assign lfsr_en = (state == GAP) || issue;
  assign busy    = (state == GAP) || (state == FLIT);
  assign done    = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rate_q     <= '0;
      dest_q     <= '0;
      num_q      <= '0;
      idx        <= '0;
      pkt_cnt    <= '0;
      flit_valid <= 1'b0;
      flit_type  <= 2'b00;
      flit_data  <= 8'h00;
    end else begin
      flit_valid <= issue;
      // {tail, head}: single-flit packets get both bits.
      flit_type  <= issue ? {is_tail, is_head} : 2'b00;
      if (!issue)
        flit_data <= 8'h00;
      else if (is_head)
        flit_data <= {dest_q, lfsr_in[3:0]};
      else
        flit_data <= lfsr_in;

      unique case (state)
        IDLE, DONE: begin
          if (can_start) begin
            rate_q  <= cfg_rate;
            dest_q  <= cfg_dest;
            num_q   <= cfg_num_pkts;
            pkt_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
          end else if (lfsr_in < rate_q) begin
            idx   <= '0;
            state <= FLIT;
          end
        end
        FLIT: begin
          if (issue) begin
            if (is_tail) begin
              idx     <= '0;
              pkt_cnt <= pkt_nxt;
              if (last_pkt)
                state <= DONE;
              else if (stop)
                state <= IDLE;
              else
                state <= GAP;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Simultaneous issue and return cancel; a return into a full
  // counter is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_cnt <= 4'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      unique case ({issue, credit_in})
        2'b10: credit_cnt <= credit_cnt - 4'd1;
        2'b01: begin
          if (credit_cnt == 4'(CREDITS))
            credit_err <= 1'b1;
          else
            credit_cnt <= credit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef TRAFFIC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (can_start) begin
      stall_cnt <= '0;
    end else if ((state == FLIT) && (credit_cnt == 4'd0)
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
